// File: rtl/prco_uart_tx_pkg.sv
// Shared FSM encoding, 8-N-1 frame constants and a constant-width helper
// for the UART transmitter and its FIFO.
package prco_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Bits needed to count 0..value-1; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prco_uart_tx_if.sv
// Core-side write port of the UART transmitter: byte strobe in, FIFO status out.
// Writes are accepted only while o_full is low; no retry, no error flag.
interface prco_uart_tx_if;
    import prco_uart_tx_pkg::*;

    logic                 i_wr_en;
    logic [DATA_BITS-1:0] i_wr_data;
    logic                 o_full;
    logic                 o_empty;

    modport master (
        output i_wr_en,
        output i_wr_data,
        input  o_full,
        input  o_empty
    );

    modport slave (
        input  i_wr_en,
        input  i_wr_data,
        output o_full,
        output o_empty
    );

endinterface

// File: rtl/prco_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; write visible on rd_data one edge later.
// Writes while full are dropped (full judged before a same-cycle pop); reads while empty are ignored.
module prco_sync_fifo
    import prco_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prco_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk50) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/prco_uart_tx.sv
// 8-N-1 UART transmitter behind a write FIFO; idle write-to-start-bit is 2 cycles, frames back-to-back.
// The core only stalls on o_full; writes presented while full are dropped.
module prco_uart_tx
    import prco_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk50,
    input  logic           rst,
    prco_uart_tx_if.slave  wr,
    output logic           o_busy,
    output logic           o_tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = clog2(DIV);
    localparam int BW  = clog2(DATA_BITS);
    localparam int QW  = clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("prco_uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [BW-1:0]        bit_q;
    logic [BW-1:0]        bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 tx_d;
    logic                 pop;
    logic                 baud_end;
    logic [DATA_BITS-1:0] head;
    logic [QW-1:0]        fifo_count;

    prco_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50   (clk50),
        .rst     (rst),
        .wr_en   (wr.i_wr_en),
        .wr_data (wr.i_wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (wr.o_full),
        .empty   (wr.o_empty),
        .count   (fifo_count)
    );

    assign o_busy   = (state_q != ST_IDLE) || (fifo_count != '0);
    assign baud_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            o_tx    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            o_tx    <= tx_d;
        end
    end

    // tx_d follows the current state; registering it puts the start bit one
    // edge after the pop and keeps the pin glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = baud_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!wr.o_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    if (!wr.o_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prco_uart_tx.sv
// Randomised scoreboard bench: a frame-level model predicts accepted bytes and start times,
// a line decoder pops and compares them independently of the stimulus.
module tb_prco_uart_tx;
    import prco_uart_tx_pkg::*;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = FRAME_BITS * DIV;
    localparam int HALF   = DIV / 2;

    logic clk50 = 1'b0;
    logic rst;
    logic o_busy;
    logic o_tx;

    prco_uart_tx_if wr();

    prco_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50  (clk50),
        .rst    (rst),
        .wr     (wr),
        .o_busy (o_busy),
        .o_tx   (o_tx)
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: bytes waiting in the FIFO, cycles left on the current frame,
    // and the scoreboard of (byte, cycle its start bit must first appear).
    int mq[$];
    int remaining = 0;
    int sb_b[$];
    int sb_c[$];
    bit exp_full  = 1'b0;
    bit exp_empty = 1'b1;
    bit exp_busy  = 1'b0;
    bit mon_en    = 1'b0;
    bit dec       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr.i_wr_en   = 1'b1;
        wr.i_wr_data = b;
        tick();
        wr.i_wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || remaining != 0 || sb_b.size() != 0 || dec) && n < 20 * FRAME) begin
            tick();
            n++;
        end
        check("drain_done", n < 20 * FRAME, 1);
        repeat (20) tick();
    endtask

    // Reference model: one frame occupies the line for FRAME cycles; a new byte
    // leaves the queue as soon as the line is free. Fullness is judged before that pop.
    initial begin
        bit full_pre;
        forever begin
            @(posedge clk50);
            cyc++;
            if (rst) begin
                mq.delete();
                sb_b.delete();
                sb_c.delete();
                remaining = 0;
            end else begin
                full_pre = (mq.size() == DEPTH);
                if (remaining > 0) remaining--;
                if (remaining == 0 && mq.size() > 0) begin
                    sb_b.push_back(mq.pop_front());
                    sb_c.push_back(cyc + 1);
                    remaining = FRAME;
                end
                if (wr.i_wr_en && !full_pre) mq.push_back(int'(wr.i_wr_data));
            end
            exp_full  = (mq.size() == DEPTH);
            exp_empty = (mq.size() == 0);
            exp_busy  = (remaining > 0) || (mq.size() > 0);
        end
    end

    // Monitor: status flags every cycle, and a mid-bit UART decoder on o_tx.
    initial begin
        int          off;
        int          t0;
        int          exp_b;
        bit          have_exp;
        logic [7:0]  acc;
        t0 = 0;
        exp_b = 0;
        have_exp = 1'b0;
        acc = '0;
        forever begin
            @(negedge clk50);
            if (!mon_en) continue;
            check("o_full", wr.o_full, exp_full);
            check("o_empty", wr.o_empty, exp_empty);
            check("o_busy", o_busy, exp_busy);
            if (rst) begin
                dec = 1'b0;
                continue;
            end
            if (!dec) begin
                if (o_tx !== 1'b1) begin
                    dec      = 1'b1;
                    t0       = cyc;
                    acc      = '0;
                    have_exp = (sb_b.size() != 0);
                    check("frame_expected", have_exp, 1);
                    if (have_exp) begin
                        exp_b = sb_b.pop_front();
                        check("start_cycle", cyc, sb_c.pop_front());
                    end
                end
            end else begin
                off = cyc - t0;
                if (off == HALF) begin
                    check("start_bit", o_tx, 0);
                end else if (off > HALF && off < 9 * DIV + HALF && (off - HALF) % DIV == 0) begin
                    acc[(off - HALF) / DIV - 1] = o_tx;
                end else if (off == 9 * DIV + HALF) begin
                    check("stop_bit", o_tx, 1);
                    if (have_exp) check("rx_byte", acc, exp_b);
                    dec = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int hi;
        int nb;
        int gap;
        rst          = 1'b1;
        wr.i_wr_en   = 1'b0;
        wr.i_wr_data = '0;

        // Reset state and a quiet line
        repeat (3) tick();
        check("rst_tx", o_tx, 1);
        check("rst_full", wr.o_full, 0);
        check("rst_empty", wr.o_empty, 1);
        check("rst_busy", o_busy, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        hi = 0;
        repeat (50) begin
            tick();
            hi += int'(o_tx);
        end
        check("idle_tx_high_50", hi, 50);

        // Single byte; busy drops FRAME cycles after the pop edge
        write_byte(8'hA5);
        n = 0;
        while (o_busy && n < 500) begin
            tick();
            n++;
        end
        check("busy_fall_cycles", n, FRAME + 1);
        drain();

        // Three back-to-back bytes
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        drain();

        // Overfill: sixth byte dropped
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i));
            if (i >= 4) check("fill_full", wr.o_full, 1);
        end
        drain();

        // Reset in the middle of data bit 3 with two bytes queued
        write_byte(8'h55);
        write_byte(8'hAA);
        write_byte(8'hBB);
        repeat (43) tick();
        rst = 1'b1;
        tick();
        check("midframe_rst_tx", o_tx, 1);
        check("midframe_rst_empty", wr.o_empty, 1);
        rst = 1'b0;
        repeat (3 * FRAME) tick();
        check("no_frames_after_rst", o_busy, 0);

        // Write on the pop edge while full: must be rejected
        for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
        n = 0;
        while (!(remaining == 1 && mq.size() == DEPTH) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check("collide_setup", n < 3 * FRAME, 1);
        write_byte(8'hEE);
        check("collide_full_after_pop", wr.o_full, 0);
        drain();

        // Randomised bursts and gaps
        for (int r = 0; r < 25; r++) begin
            nb = int'($urandom_range(1, 6));
            for (int j = 0; j < nb; j++) write_byte(8'($urandom_range(0, 255)));
            gap = int'($urandom_range(0, 2 * FRAME));
            repeat (gap) tick();
        end
        drain();

        check("scoreboard_empty", sb_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
